// File: rtl/spm_pkg.sv
// spm_pkg: shared types and constants for the SPM controller
package spm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_LAT_LO,
        S_LAT_HI,
        S_BUF_LO,
        S_BUF_HI,
        S_OP
    } spm_state_t;

    localparam int SPMEN_B  = 0;
    localparam int PGERS_B  = 1;
    localparam int PGWRT_B  = 2;
    localparam int RWWSRE_B = 4;
    localparam int RWWSB_B  = 6;
    localparam int SPMIE_B  = 7;

    localparam logic [4:0] CMD_FILL   = 5'h01;
    localparam logic [4:0] CMD_ERASE  = 5'h03;
    localparam logic [4:0] CMD_WRITE  = 5'h05;
    localparam logic [4:0] CMD_RWWSRE = 5'h11;

    localparam logic [1:0] BKSEL_IDLE    = 2'b00;
    localparam logic [1:0] BKSEL_BOTH    = 2'b01;
    localparam logic [1:0] BKSEL_RWW_WR  = 2'b10;
    localparam logic [1:0] BKSEL_NRWW_WR = 2'b11;

    localparam logic [2:0] NRWW_TAG = 3'b111;

    typedef struct packed {
        logic [7:0] dbi;
        logic       adr0;
        logic       db_wr;
        logic       en_adr_lat;
        logic       en_buf;
        logic       erase;
        logic       prog;
        logic [1:0] bksel;
        logic       stall;
        logic       halt;
        logic       irq;
    } spm_out_t;

    function automatic logic is_cmd(input logic [4:0] c);
        return c inside {CMD_FILL, CMD_ERASE, CMD_WRITE, CMD_RWWSRE};
    endfunction

endpackage

// File: rtl/spm_if.sv
// spm_if: CPU-side SPM bus plus the program-memory control bus
interface spm_if;
    logic        spmcsr_we;
    logic [7:0]  spmcsr_wdata;
    logic [7:0]  spmcsr_rdata;
    logic        spm_exec;
    logic [15:0] z_ptr;
    logic [15:0] r1r0;
    logic        spm_stall;
    logic        cpu_halt;
    logic        spm_irq;
    logic [7:0]  pm_dbi;
    logic        pm_adr0;
    logic        pm_db_wr;
    logic        pm_en_adr_lat;
    logic        pm_en_buf;
    logic        pm_erase;
    logic        pm_prog;
    logic [1:0]  pm_bksel;

    modport master (
        output spmcsr_we, spmcsr_wdata, spm_exec, z_ptr, r1r0,
        input  spmcsr_rdata, spm_stall, cpu_halt, spm_irq,
        input  pm_dbi, pm_adr0, pm_db_wr, pm_en_adr_lat, pm_en_buf, pm_erase, pm_prog, pm_bksel
    );

    modport slave (
        input  spmcsr_we, spmcsr_wdata, spm_exec, z_ptr, r1r0,
        output spmcsr_rdata, spm_stall, cpu_halt, spm_irq,
        output pm_dbi, pm_adr0, pm_db_wr, pm_en_adr_lat, pm_en_buf, pm_erase, pm_prog, pm_bksel
    );
endinterface

// File: rtl/spm_op_timer.sv
// spm_op_timer: loadable down-counter with a done pulse on its final decrement
module spm_op_timer #(
    parameter int MAX = 51040,
    localparam int W = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q;

    // count down from the loaded value, parking at zero
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign done_o = en_i & ~load_i & (cnt_q == W'(1));
endmodule

// File: rtl/spm_controller.sv
// spm_controller: owns SPMCSR and sequences SPM commands onto the flash control bus
module spm_controller
    import spm_pkg::*;
#(
    parameter int OP_CYCLES  = 51040,
    parameter int ARM_WINDOW = 4
) (
    input logic clk,
    input logic rst,
    spm_if.slave bus
);
    localparam int W = $clog2(OP_CYCLES + 1);

    spm_state_t  state_q, state_d;
    logic [4:0]  cmd_q, cmd_d;
    logic        spmie_q, spmie_d, rwwsb_q, rwwsb_d;
    logic [14:0] z_q, z_d;
    logic [15:0] d_q, d_d;
    spm_out_t    out_q, out_d;
    logic        arm_ok, accept, nrww, t_load, t_en, t_done;
    logic [W-1:0] t_val;

    assign arm_ok = bus.spmcsr_we & (state_q == S_IDLE | state_q == S_ARMED) & is_cmd(bus.spmcsr_wdata[4:0]);
    assign accept = (state_q == S_ARMED) & bus.spm_exec & ~bus.spmcsr_we;
    assign nrww   = z_q[14:12] == NRWW_TAG;
    // one timer serves both the arm window and the erase/write hold time
    assign t_load = arm_ok | (state_q == S_LAT_HI);
    assign t_val  = arm_ok ? W'(ARM_WINDOW) : W'(OP_CYCLES);
    assign t_en   = ((state_q == S_ARMED) & ~arm_ok & ~accept) | (state_q == S_OP);

    spm_op_timer #(.MAX(OP_CYCLES)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (t_load),
        .load_val_i(t_val),
        .en_i      (t_en),
        .done_o    (t_done)
    );

    // state and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            spmie_q <= 1'b0;
            rwwsb_q <= 1'b0;
            z_q     <= '0;
            d_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            spmie_q <= spmie_d;
            rwwsb_q <= rwwsb_d;
            z_q     <= z_d;
            d_q     <= d_d;
            out_q   <= out_d;
        end
    end

    // next-state: arm, dispatch on exec, run the byte sequence or the timed op
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = arm_ok ? S_ARMED : S_IDLE;
            S_ARMED:  state_d = arm_ok ? S_ARMED
                              : accept ? (cmd_q == CMD_RWWSRE ? S_IDLE : S_LAT_LO)
                              : t_done ? S_IDLE : S_ARMED;
            S_LAT_LO: state_d = cmd_q == CMD_FILL ? S_BUF_LO : S_LAT_HI;
            S_LAT_HI: state_d = S_OP;
            S_BUF_LO: state_d = S_BUF_HI;
            S_BUF_HI: state_d = S_IDLE;
            S_OP:     state_d = t_done ? S_IDLE : S_OP;
            default:  state_d = S_IDLE;
        endcase
    end

    // SPMCSR update and outputs decoded from the state being entered
    always_comb begin
        spmie_d = bus.spmcsr_we ? bus.spmcsr_wdata[SPMIE_B] : spmie_q;
        cmd_d   = arm_ok ? bus.spmcsr_wdata[4:0] : (state_d == S_IDLE ? 5'h00 : cmd_q);
        rwwsb_d = (state_q == S_LAT_HI && !nrww) ? 1'b1
                : (accept && cmd_q == CMD_RWWSRE) ? 1'b0 : rwwsb_q;
        z_d     = accept ? bus.z_ptr[14:0] : z_q;
        d_d     = accept ? bus.r1r0 : d_q;
        out_d            = '0;
        out_d.db_wr      = state_d inside {S_LAT_LO, S_LAT_HI, S_BUF_LO, S_BUF_HI};
        out_d.stall      = out_d.db_wr;
        out_d.en_adr_lat = state_d inside {S_LAT_LO, S_LAT_HI};
        out_d.en_buf     = state_d inside {S_BUF_LO, S_BUF_HI};
        out_d.adr0       = state_d inside {S_LAT_HI, S_BUF_HI};
        out_d.dbi        = state_d == S_LAT_LO ? z_d[7:0]
                         : state_d == S_LAT_HI ? {1'b0, z_d[14:8]}
                         : state_d == S_BUF_LO ? d_d[7:0]
                         : state_d == S_BUF_HI ? d_d[15:8] : 8'h00;
        out_d.erase      = (state_d == S_OP) & (cmd_d == CMD_ERASE);
        out_d.prog       = (state_d == S_OP) & (cmd_d == CMD_WRITE);
        out_d.halt       = (state_d == S_OP) & nrww;
        out_d.bksel      = state_d != S_OP ? BKSEL_IDLE : nrww ? BKSEL_NRWW_WR : BKSEL_RWW_WR;
        out_d.irq        = spmie_d & ~cmd_d[SPMEN_B];
    end

    assign bus.spmcsr_rdata  = {spmie_q, rwwsb_q, 1'b0, cmd_q[RWWSRE_B], 1'b0, cmd_q[PGWRT_B], cmd_q[PGERS_B], cmd_q[SPMEN_B]};
    assign bus.spm_stall     = out_q.stall;
    assign bus.cpu_halt      = out_q.halt;
    assign bus.spm_irq       = out_q.irq;
    assign bus.pm_dbi        = out_q.dbi;
    assign bus.pm_adr0       = out_q.adr0;
    assign bus.pm_db_wr      = out_q.db_wr;
    assign bus.pm_en_adr_lat = out_q.en_adr_lat;
    assign bus.pm_en_buf     = out_q.en_buf;
    assign bus.pm_erase      = out_q.erase;
    assign bus.pm_prog       = out_q.prog;
    assign bus.pm_bksel      = out_q.bksel;
endmodule

// File: tb/tb_spm_controller.sv
// tb_spm_controller: vector table for SPMCSR writes plus scoreboarded SPM sequences
module tb_spm_controller;
    localparam int OP = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [10:0] beats[$];

    spm_if bus();

    spm_controller #(.OP_CYCLES(OP), .ARM_WINDOW(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] wdata;
        logic [7:0] rd;
        logic       irq;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_csr(input logic [7:0] v);
        bus.spmcsr_we = 1'b1;
        bus.spmcsr_wdata = v;
        tick();
        bus.spmcsr_we = 1'b0;
    endtask

    task automatic exec(input logic [15:0] z, input logic [15:0] d);
        bus.spm_exec = 1'b1;
        bus.z_ptr = z;
        bus.r1r0 = d;
        tick();
        bus.spm_exec = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] ep, input logic [1:0] bk,
                          input logic halt, input logic [7:0] rd_op, input logic [7:0] rd_after);
        int n = 0;
        logic bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.pm_erase | bus.pm_prog) break;
            tick();
        end
        while ((bus.pm_erase | bus.pm_prog) && n < OP + 50) begin
            if ({bus.pm_erase, bus.pm_prog} !== ep || bus.pm_bksel !== bk ||
                bus.cpu_halt !== halt || bus.spmcsr_rdata !== rd_op) bad = 1'b1;
            n++;
            tick();
        end
        chk({name, "_len"}, n, OP);
        chk({name, "_sides"}, bad, 0);
        chk({name, "_after"}, {bus.spmcsr_rdata, bus.pm_bksel, bus.cpu_halt}, {rd_after, 2'b00, 1'b0});
    endtask

    // program-memory byte beats are popped from the scoreboard as they appear
    always @(posedge clk) begin
        #1;
        if (!rst && bus.pm_db_wr) begin
            if (beats.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got dbi %h expected no beat", bus.pm_dbi);
            end else chk("beat", {bus.pm_en_adr_lat, bus.pm_en_buf, bus.pm_adr0, bus.pm_dbi}, beats.pop_front());
        end
    end

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0};
        vecs[1] = '{8'h01, 8'h01, 1'b0};
        vecs[2] = '{8'h03, 8'h03, 1'b0};
        vecs[3] = '{8'h05, 8'h05, 1'b0};
        vecs[4] = '{8'h11, 8'h11, 1'b0};
        vecs[5] = '{8'h81, 8'h81, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b1};
        vecs[7] = '{8'h8F, 8'h80, 1'b1};
        vecs[8] = '{8'h09, 8'h00, 1'b0};
        vecs[9] = '{8'h07, 8'h00, 1'b0};
        bus.spmcsr_we = 1'b0;
        bus.spmcsr_wdata = 8'h00;
        bus.spm_exec = 1'b0;
        bus.z_ptr = 16'h0000;
        bus.r1r0 = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_csr", bus.spmcsr_rdata, 8'h00);
        chk("reset_ctl", {bus.spm_stall, bus.cpu_halt, bus.spm_irq, bus.pm_db_wr, bus.pm_en_adr_lat,
                          bus.pm_en_buf, bus.pm_erase, bus.pm_prog, bus.pm_adr0}, 0);
        chk("reset_bus", {bus.pm_dbi, bus.pm_bksel}, 0);

        for (int i = 0; i < 10; i++) begin
            wr_csr(vecs[i].wdata);
            chk("tbl_rd", bus.spmcsr_rdata, vecs[i].rd);
            chk("tbl_irq", bus.spm_irq, vecs[i].irq);
            repeat (5) tick();
            chk("tbl_rd_idle", bus.spmcsr_rdata, {vecs[i].wdata[7], 7'h00});
            chk("tbl_irq_idle", bus.spm_irq, vecs[i].wdata[7]);
        end

        wr_csr(8'h01);
        repeat (3) tick();
        chk("window_last", bus.spmcsr_rdata, 8'h01);
        tick();
        chk("window_expired", bus.spmcsr_rdata, 8'h00);
        exec(16'h1234, 16'h5678);
        repeat (3) tick();
        chk("late_exec_stall", bus.spm_stall, 0);

        wr_csr(8'h01);
        bus.spmcsr_we = 1'b1;
        bus.spmcsr_wdata = 8'h01;
        bus.spm_exec = 1'b1;
        tick();
        bus.spmcsr_we = 1'b0;
        bus.spm_exec = 1'b0;
        repeat (3) tick();
        chk("rearm_window", bus.spmcsr_rdata, 8'h01);
        tick();
        chk("rearm_expired", bus.spmcsr_rdata, 8'h00);

        wr_csr(8'h01);
        tick();
        beats.push_back({3'b100, 8'h36});
        beats.push_back({3'b010, 8'hEF});
        beats.push_back({3'b011, 8'hBE});
        exec(16'h1A36, 16'hBEEF);
        chk("fill_stall", bus.spm_stall, 1);
        repeat (3) tick();
        chk("fill_done", {bus.spmcsr_rdata, bus.spm_stall, bus.pm_db_wr}, {8'h00, 2'b00});

        wr_csr(8'h03);
        beats.push_back({3'b100, 8'h00});
        beats.push_back({3'b101, 8'h70});
        exec(16'h7000, 16'h0000);
        run_op("nrww_erase", 2'b10, 2'b11, 1'b1, 8'h03, 8'h00);

        wr_csr(8'h05);
        beats.push_back({3'b100, 8'h80});
        beats.push_back({3'b101, 8'h0C});
        exec(16'h0C80, 16'h0000);
        run_op("rww_write", 2'b01, 2'b10, 1'b0, 8'h45, 8'h40);

        wr_csr(8'h80);
        chk("irq_set", {bus.spmcsr_rdata, bus.spm_irq}, {8'hC0, 1'b1});
        wr_csr(8'h91);
        chk("rwwsre_armed", {bus.spmcsr_rdata, bus.spm_irq}, {8'hD1, 1'b0});
        exec(16'h0000, 16'h0000);
        chk("rwwsre_done", {bus.spmcsr_rdata, bus.spm_irq}, {8'h80, 1'b1});

        wr_csr(8'h05);
        beats.push_back({3'b100, 8'h80});
        beats.push_back({3'b101, 8'h0C});
        exec(16'h0C80, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            if (bus.pm_prog) break;
            tick();
        end
        repeat (100) tick();
        chk("mid_op", {bus.pm_prog, bus.spmcsr_rdata}, {1'b1, 8'h45});
        rst = 1'b1;
        tick();
        chk("reset_in_op", {bus.pm_prog, bus.pm_bksel, bus.spmcsr_rdata}, 0);
        rst = 1'b0;
        tick();
        chk("beats_left", beats.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
